// File: rtl/mv_filter_multi.sv
// Multi-channel moving-average filter with runtime window 2^win_log2 and trigger decimation.
// Latency: qualifying trig in cycle T -> dout_valid in T+2; one sample per clock, no backpressure.
module mv_filter_multi #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 32,
  parameter int MAX_LOG2_WIN = 13,
  parameter int DIV_W        = 6,
  localparam int WL_W        = $clog2(MAX_LOG2_WIN + 1)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     trig,
  input  logic [DIV_W-1:0]         div_factor,
  input  logic [WL_W-1:0]          win_log2,
  input  logic                     clear,
  input  logic [N_CH*DATA_W-1:0]   din,
  output logic [N_CH*DATA_W-1:0]   dout,
  output logic                     dout_valid,
  output logic                     filled
);

  localparam int ACC_W = DATA_W + MAX_LOG2_WIN;
  localparam int DEPTH = 1 << MAX_LOG2_WIN;
  localparam int IDX_W = MAX_LOG2_WIN;
  localparam int CNT_W = MAX_LOG2_WIN + 1;

  logic [WL_W-1:0]          eff_in;
  logic [WL_W-1:0]          eff_q;
  logic [CNT_W-1:0]         win_len;
  logic                     flush;
  logic                     qualify;
  logic                     full;
  logic                     idx_last;

  logic [DIV_W-1:0]         dec_cnt;
  logic [IDX_W-1:0]         idx;
  logic [CNT_W-1:0]         fill_cnt;

  logic                     s1_vld;
  logic                     s1_full;
  logic                     s1_fill;
  logic [N_CH*DATA_W-1:0]   s1_din;
  logic [N_CH*DATA_W-1:0]   s1_old;
  logic [N_CH*DATA_W-1:0]   mem [DEPTH];

  logic signed [ACC_W-1:0]  sum_q   [N_CH];
  logic signed [ACC_W-1:0]  sum_nx  [N_CH];
  logic signed [ACC_W-1:0]  shifted [N_CH];
  logic [N_CH*DATA_W-1:0]   avg_nx;

  assign eff_in   = (win_log2 > WL_W'(MAX_LOG2_WIN)) ? WL_W'(MAX_LOG2_WIN) : win_log2;
  assign win_len  = CNT_W'(1) << eff_q;
  // eff_q updates in the same edge that flushes, so a window change never mixes with old state
  assign flush    = clear | (eff_in != eff_q);
  assign qualify  = trig & ~flush &
                    ((div_factor <= DIV_W'(1)) || (dec_cnt >= div_factor - DIV_W'(1)));
  assign full     = fill_cnt >= win_len;
  assign idx_last = CNT_W'(idx) == (win_len - CNT_W'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      eff_q    <= '0;
      dec_cnt  <= '0;
      idx      <= '0;
      fill_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_full  <= 1'b0;
      s1_fill  <= 1'b0;
      s1_din   <= '0;
    end else begin
      eff_q <= eff_in;
      if (flush) begin
        dec_cnt  <= '0;
        idx      <= '0;
        fill_cnt <= '0;
        s1_vld   <= 1'b0;
      end else begin
        s1_vld <= qualify;
        if (trig) begin
          dec_cnt <= qualify ? '0 : dec_cnt + DIV_W'(1);
        end
        if (qualify) begin
          idx      <= idx_last ? '0 : idx + IDX_W'(1);
          if (!full) begin
            fill_cnt <= fill_cnt + CNT_W'(1);
          end
          s1_din   <= din;
          s1_full  <= full;
          s1_fill  <= full || ((fill_cnt + CNT_W'(1)) == win_len);
        end
      end
    end
  end

  // Read-first RAM: the entry leaving the window is fetched as the new sample overwrites it
  always_ff @(posedge clk) begin
    if (qualify) begin
      s1_old   <= mem[idx];
      mem[idx] <= din;
    end
  end

  always_comb begin
    avg_nx = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum_nx[k] = sum_q[k]
                + ACC_W'(signed'(s1_din[k*DATA_W +: DATA_W]))
                - (s1_full ? ACC_W'(signed'(s1_old[k*DATA_W +: DATA_W])) : {ACC_W{1'b0}});
      shifted[k] = sum_nx[k] >>> eff_q;
      avg_nx[k*DATA_W +: DATA_W] = shifted[k][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < N_CH; k++) begin
        sum_q[k] <= '0;
      end
      dout       <= '0;
      dout_valid <= 1'b0;
      filled     <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < N_CH; k++) begin
        sum_q[k] <= '0;
      end
      dout_valid <= 1'b0;
      filled     <= 1'b0;
    end else if (s1_vld) begin
      for (int k = 0; k < N_CH; k++) begin
        sum_q[k] <= sum_nx[k];
      end
      dout       <= avg_nx;
      dout_valid <= 1'b1;
      filled     <= s1_fill;
    end else begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mv_filter_multi.sv
// Scoreboard bench for mv_filter_multi: directed vectors, expected results queued at issue time.
module tb_mv_filter_multi;
  localparam int N_CH = 2;
  localparam int DATA_W = 32;
  localparam int MAX_LOG2_WIN = 13;
  localparam int DIV_W = 6;
  localparam int WL_W = $clog2(MAX_LOG2_WIN + 1);

  logic                   clk = 1'b0;
  logic                   n_rst;
  logic                   trig;
  logic [DIV_W-1:0]       div_factor;
  logic [WL_W-1:0]        win_log2;
  logic                   clear;
  logic [N_CH*DATA_W-1:0] din;
  logic [N_CH*DATA_W-1:0] dout;
  logic                   dout_valid;
  logic                   filled;

  mv_filter_multi #(
    .N_CH(N_CH), .DATA_W(DATA_W), .MAX_LOG2_WIN(MAX_LOG2_WIN), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .n_rst(n_rst), .trig(trig), .div_factor(div_factor),
    .win_log2(win_log2), .clear(clear), .din(din), .dout(dout),
    .dout_valid(dout_valid), .filled(filled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ef;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  bit   sb_off = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Monitor: every presented result is matched against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (n_rst && dout_valid && !sb_off) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_pulse: cyc %0d dout %h filled %b, required no pulse", cyc, dout, filled);
      end else begin
        e = q.pop_front();
        if (dout === {e.e1, e.e0} && filled === e.ef && cyc == e.t) passes++;
        else $display("FAIL result: got cyc %0d dout %h filled %b, want cyc %0d dout %h filled %b",
                      cyc, dout, filled, e.t, {e.e1, e.e0}, e.ef);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [31:0] a, input logic [31:0] b, input bit push,
                      input logic [31:0] e0, input logic [31:0] e1, input logic ef);
    exp_t e;
    din  = {b, a};
    trig = 1'b1;
    if (push) begin
      e.t = cyc + 2; e.e0 = e0; e.e1 = e1; e.ef = ef;
      q.push_back(e);
    end
    tick();
    trig = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    longint t0, t1;
    n_rst = 1'b0; trig = 1'b0; clear = 1'b0; din = '0;
    div_factor = 6'd1; win_log2 = 4'd2;
    repeat (3) tick();
    chk("reset_dout", dout, 64'd0);
    chk("reset_valid", 64'(dout_valid), 64'd0);
    chk("reset_filled", 64'(filled), 64'd0);
    n_rst = 1'b1;
    repeat (2) tick();

    // W=4 averaging, ch1 negative constant
    samp(4,  -8, 1, 1,  -2, 0);
    samp(8,  -8, 1, 3,  -4, 0);
    samp(12, -8, 1, 6,  -6, 0);
    samp(16, -8, 1, 10, -8, 1);
    samp(20, -8, 1, 14, -8, 1);
    drain("drain_w4");

    // W=8, arithmetic shift of negative sums
    win_log2 = 4'd3;
    repeat (2) tick();
    for (int i = 1; i <= 10; i++)
      samp(0, -8, 1, 0, -((i < 8) ? i : 8), i >= 8);
    drain("drain_w8_neg");

    // Pass-through with decimation by 4, then no decimation
    win_log2 = 4'd0;
    div_factor = 6'd4;
    repeat (2) tick();
    for (int i = 1; i <= 12; i++)
      samp(i, -i, (i % 4) == 0, i, -i, 1);
    drain("drain_div4");
    div_factor = 6'd0;
    for (int i = 1; i <= 12; i++)
      samp(100 + i, -(100 + i), 1, 100 + i, -(100 + i), 1);
    drain("drain_div0");

    // Clear colliding with a qualifying trig, then in-flight discard
    win_log2 = 4'd2;
    div_factor = 6'd1;
    repeat (2) tick();
    samp(8, 1, 1, 2, 0, 0);
    samp(8, 1, 1, 4, 0, 0);
    samp(8, 1, 1, 6, 0, 0);
    samp(8, 1, 1, 8, 1, 1);
    tick();
    clear = 1'b1;
    samp(100, 100, 0, 0, 0, 0);
    clear = 1'b0;
    samp(20, -3, 1, 5, -1, 0);
    samp(40, 40, 0, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drain("drain_clear");
    chk("filled_after_clear", 64'(filled), 64'd0);

    // Window change mid-stream flushes
    win_log2 = 4'd3;
    repeat (2) tick();
    samp(8, 0, 1, 1, 0, 0);
    samp(8, 0, 1, 2, 0, 0);
    samp(8, 0, 1, 3, 0, 0);
    repeat (3) tick();
    win_log2 = 4'd1;
    repeat (2) tick();
    samp(6,  0, 1, 3, 0, 0);
    samp(10, 0, 1, 8, 0, 1);
    drain("drain_winchg");

    // Full 8192-sample window of extreme values
    win_log2 = 4'd13;
    repeat (2) tick();
    for (int k = 1; k <= 8192; k++) begin
      t0 = (longint'(k) * longint'(32'h7FFFFFFF)) >>> 13;
      t1 = (-(longint'(k) <<< 31)) >>> 13;
      samp(32'h7FFFFFFF, 32'h80000000, 1, t0[31:0], t1[31:0], k == 8192);
    end
    drain("drain_burst");
    chk("burst_final", dout, {32'h80000000, 32'h7FFFFFFF});

    // Asynchronous reset in the middle of a burst
    sb_off = 1'b1;
    samp(32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 0);
    samp(32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 0);
    trig = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_dout", dout, 64'd0);
    chk("async_rst_valid", 64'(dout_valid), 64'd0);
    chk("async_rst_filled", 64'(filled), 64'd0);
    trig = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    q.delete();
    sb_off = 1'b0;
    repeat (2) tick();
    samp(8192, 0, 1, 1, 0, 0);
    drain("drain_post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mv_filter_multi.md
MV_FILTER_MULTI -- requirements
Module: mv_filter_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, which sets the number of independent channels.
REQ-002 The block SHALL have parameter DATA_W, default 32, which sets the signed sample width per channel.
REQ-003 The block SHALL have parameter MAX_LOG2_WIN, default 13, which sets the maximum window as 2^MAX_LOG2_WIN samples per channel.
REQ-004 The block SHALL have parameter DIV_W, default 6, which sets the width of div_factor.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port trig, input, 1 bit: sample trigger pulse; one trig per clk high counts as one event.
REQ-008 The block SHALL have port div_factor, input, DIV_W bits: trigger decimation ratio; the values 0 and 1 both mean no decimation.
REQ-009 The block SHALL have port win_log2, input, $clog2(MAX_LOG2_WIN+1) bits: runtime window exponent W=2^win_log2.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous flush of the filter state.
REQ-011 The block SHALL have port din, input, N_CH*DATA_W bits: packed signed samples, with channel k at bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port dout, output, N_CH*DATA_W bits: packed signed averages, using the same packing as din.
REQ-013 The block SHALL have port dout_valid, output, 1 bit: one-cycle pulse when dout updates.
REQ-014 The block SHALL have port filled, output, 1 bit: high once W samples have been accumulated since the last flush.

Function
REQ-015 A trig SHALL qualify when the decimation counter is >= div_factor-1, or when div_factor<=1; on qualify the counter SHALL go to 0, otherwise it SHALL increment by 1.
REQ-016 A change of div_factor SHALL take effect at the next trig; there SHALL be no flush.
REQ-017 The effective exponent SHALL be min(win_log2, MAX_LOG2_WIN); the value 0 SHALL give a pass-through, with dout = last sample.
REQ-018 On a qualifying trig in cycle T, din SHALL be captured in cycle T for all channels simultaneously.
REQ-019 For each channel, the update SHALL be sum_next = sum + din - old, where old is the stored buffer entry at index if the fill count is >= W, and 0 otherwise.
REQ-020 Each buffer SHALL hold 2^MAX_LOG2_WIN entries; the index SHALL wrap from W-1 to 0 using the effective W, not the buffer depth.
REQ-021 The accumulator SHALL be signed, DATA_W+MAX_LOG2_WIN bits wide, and SHALL never overflow.
REQ-022 dout SHALL be computed as sum_next >>> eff_log2, with arithmetic shift, truncation toward minus infinity and no saturation; it SHALL include the current sample, with no stale-sum lag.
REQ-023 dout and dout_valid SHALL be registered: a qualifying trig in cycle T SHALL produce dout_valid high in cycle T+2 for exactly one cycle.
REQ-024 Throughput SHALL be one sample per clock: back-to-back qualifying trigs SHALL each produce a result, in order.
REQ-025 The fill count SHALL saturate at W; filled SHALL rise in the cycle the W-th sample's result is presented, i.e. together with its dout_valid.
REQ-026 Before filled is high, dout SHALL be the zero-padded average (sum of the samples taken so far >>> eff_log2).
REQ-027 Flush SHALL set sum=0, index=0, fill count=0, decimation counter=0 and filled=0; dout SHALL hold its value and the buffer contents are not cleared.
REQ-028 Flush SHALL occur on clear=1, or in the cycle after eff_log2 changes value.
REQ-029 If clear and trig occur in the same cycle, clear SHALL win: the sample is dropped and the counter is not advanced.
REQ-030 Results still in flight when a flush occurs SHALL be discarded: no dout_valid for them.
REQ-031 trig with no qualify SHALL change nothing except the decimation counter.

Reset
REQ-032 While n_rst=0, dout, dout_valid, filled, sum, index, fill count, decimation counter and pipeline valids SHALL all be 0.
REQ-033 Reset assertion SHALL act asynchronously; after release, the first qualifying trig SHALL behave as the first sample after a flush.
REQ-034 Buffer RAM SHALL NOT require reset, since the fill-count gating makes its contents irrelevant.

Verification
REQ-035 With N_CH=2, win_log2=2, div=1, ch0 samples 4,8,12,16,20 -> dout ch0 = 1,3,6,10,14; filled rises with the 4th result; each result is at T+2.
REQ-036 With ch1 constant -8 and win_log2=3 -> outputs -1,-2,...,-8 after 8 samples, then stay at -8; the check confirms arithmetic shift.
REQ-037 With div_factor=4 and 12 consecutive trigs -> 3 dout_valid pulses, for trigs 4, 8 and 12; with div_factor=0 -> 12 pulses.
REQ-038 With clear on the same cycle as a qualifying trig while filled=1 -> no pulse for that sample; the next sample x yields dout = x>>>win_log2 and filled=0.
REQ-039 Changing win_log2 from 3 to 1 mid-stream -> flush; the following samples 6,10 yield 3,8; filled rises after 2 samples.
REQ-040 With extreme inputs, DATA_W=32 and 8192 samples of 0x7FFFFFFF -> no overflow, and final dout is 0x7FFFFFFF; asserting n_rst mid-burst sets all outputs to 0 immediately.
